// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - RISC-V fetch stage: PC, imem req/ack, decode valid/ready, redirect
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imemReq,
  output logic [31:0] o_imemAddr,
  input  logic        i_imemAck,
  input  logic [31:0] i_imemData,
  output logic        o_instrValid,
  input  logic        i_instrReady,
  output logic [31:0] o_instr,
  output logic [6:0]  o_operand,
  output logic [2:0]  o_funct3,
  output logic        o_funct7bit5,
  output logic [31:0] o_pc,
  input  logic        i_redirectEn,
  input  logic [31:0] i_redirectPc,
  output logic        o_fetchError
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        error_q, error_d;
  logic        redirect_aligned;

  assign redirect_aligned = (i_redirectPc[1:0] == 2'b00);

  // Next-state logic; redirect outranks both ack and ready
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    error_d = error_q;
    case (state_q)
      FETCH: begin
        if (i_redirectEn) begin
          if (redirect_aligned) begin
            pc_d = i_redirectPc;
          end else begin
            state_d = HALT;
            error_d = 1'b1;
          end
        end else if (i_imemAck) begin
          instr_d = i_imemData;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (i_redirectEn) begin
          if (redirect_aligned) begin
            pc_d    = i_redirectPc;
            state_d = FETCH;
          end else begin
            state_d = HALT;
            error_d = 1'b1;
          end
        end else if (i_instrReady) begin
          pc_d    = pc_q + 32'd4;
          state_d = FETCH;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      error_q <= error_d;
    end
  end

  assign o_imemReq    = (state_q == FETCH) && !i_rst;
  assign o_instrValid = (state_q == HOLD);
  assign o_imemAddr   = pc_q;
  assign o_pc         = pc_q;
  assign o_instr      = instr_q;
  assign o_operand    = instr_q[6:0];
  assign o_funct3     = instr_q[14:12];
  assign o_funct7bit5 = instr_q[30];
  assign o_fetchError = error_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [6:0]  operand;
  logic [2:0]  funct3;
  logic        funct7bit5;
  logic [31:0] pc;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        fetch_error;

  int checks = 0;
  int errors = 0;

  instruction_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .o_imemReq    (imem_req),
    .o_imemAddr   (imem_addr),
    .i_imemAck    (imem_ack),
    .i_imemData   (imem_data),
    .o_instrValid (instr_valid),
    .i_instrReady (instr_ready),
    .o_instr      (instr),
    .o_operand    (operand),
    .o_funct3     (funct3),
    .o_funct7bit5 (funct7bit5),
    .o_pc         (pc),
    .i_redirectEn (redirect_en),
    .i_redirectPc (redirect_pc),
    .o_fetchError (fetch_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_data = 32'h0; instr_ready = 1'b0;
    redirect_en = 1'b0; redirect_pc = 32'h0;

    // reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_req", imem_req, 0);
    end
    check("rst_pc", pc, 32'h100);
    check("rst_instr", instr, 32'h13);
    check("rst_operand", operand, 7'b0010011);
    check("rst_funct3", funct3, 0);
    check("rst_f7b5", funct7bit5, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_err", fetch_error, 0);

    // first request right after release
    rst = 1'b0;
    #1;
    check("first_req", imem_req, 1);
    check("first_addr", imem_addr, 32'h100);

    // three wait states
    for (int i = 0; i < 3; i++) begin
      step();
      check("wait_req", imem_req, 1);
      check("wait_addr", imem_addr, 32'h100);
      check("wait_valid", instr_valid, 0);
      check("wait_instr", instr, 32'h13);
    end

    // streaming, zero-wait memory, ready high
    imem_ack = 1'b1; instr_ready = 1'b1; imem_data = 32'h00500093;
    step();
    check("s1_valid", instr_valid, 1);
    check("s1_req", imem_req, 0);
    check("s1_instr", instr, 32'h00500093);
    check("s1_pc", pc, 32'h100);
    imem_data = 32'h40208133;
    step();
    check("s2f_valid", instr_valid, 0);
    check("s2f_addr", imem_addr, 32'h104);
    check("s2f_req", imem_req, 1);
    step();
    check("s2_valid", instr_valid, 1);
    check("s2_instr", instr, 32'h40208133);
    check("s2_operand", operand, 7'b0110011);
    check("s2_funct3", funct3, 3'b000);
    check("s2_f7b5", funct7bit5, 1);
    check("s2_pc", pc, 32'h104);
    imem_data = 32'h0000A303;
    step();
    check("s3f_addr", imem_addr, 32'h108);
    check("s3f_valid", instr_valid, 0);
    instr_ready = 1'b0;
    step();
    check("s3_valid", instr_valid, 1);
    check("s3_instr", instr, 32'h0000A303);
    check("s3_funct3", funct3, 3'b010);
    check("s3_pc", pc, 32'h108);
    imem_ack = 1'b0;

    // decode backpressure for four cycles
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_valid", instr_valid, 1);
      check("bp_req", imem_req, 0);
      check("bp_pc", pc, 32'h108);
      check("bp_instr", instr, 32'h0000A303);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("bp_next_addr", imem_addr, 32'h10C);
    check("bp_next_req", imem_req, 1);

    // redirect wins over same-cycle ack
    imem_ack = 1'b1; imem_data = 32'hDEADBEEF; redirect_en = 1'b1; redirect_pc = 32'h200;
    step();
    redirect_en = 1'b0;
    check("rda_req", imem_req, 1);
    check("rda_addr", imem_addr, 32'h200);
    check("rda_valid", instr_valid, 0);
    check("rda_instr", instr, 32'h0000A303);

    // fetch 0x200, accept, fetch 0x204 into HOLD
    imem_data = 32'h12345678; instr_ready = 1'b1;
    step();
    check("r200_pc", pc, 32'h200);
    step();
    check("r204_addr", imem_addr, 32'h204);
    instr_ready = 1'b0;
    step();
    check("r204_valid", instr_valid, 1);
    check("r204_pc", pc, 32'h204);
    imem_ack = 1'b0;

    // redirect in HOLD with ready high
    instr_ready = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h200;
    step();
    redirect_en = 1'b0; instr_ready = 1'b0;
    check("rdh_pc", pc, 32'h200);
    check("rdh_valid", instr_valid, 0);
    check("rdh_req", imem_req, 1);

    // PC wrap at top of address space
    redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_en = 1'b0;
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0; instr_ready = 1'b1;
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    step();
    instr_ready = 1'b0;
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_req", imem_req, 1);

    // misaligned redirect halts
    redirect_en = 1'b1; redirect_pc = 32'h202;
    step();
    check("halt_err", fetch_error, 1);
    check("halt_req", imem_req, 0);
    check("halt_valid", instr_valid, 0);
    check("halt_pc", pc, 32'h0);
    redirect_pc = 32'h400; imem_ack = 1'b1; instr_ready = 1'b1;
    step();
    step();
    redirect_en = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
    check("halt_stick_err", fetch_error, 1);
    check("halt_stick_req", imem_req, 0);
    check("halt_stick_pc", pc, 32'h0);

    // reset out of HALT
    rst = 1'b1;
    #1;
    check("hrst_req_comb", imem_req, 0);
    step();
    check("hrst_err", fetch_error, 0);
    check("hrst_pc", pc, 32'h100);
    check("hrst_instr", instr, 32'h13);
    check("hrst_req", imem_req, 0);
    rst = 1'b0;
    #1;
    check("hrst_first_req", imem_req, 1);
    check("hrst_first_addr", imem_addr, 32'h100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
